// File: rtl/game_round_ctrl.sv
// ============================================================================
// Module   : game_round_ctrl
// Purpose  : Round sequencer for a shooter/catcher game: countdown, single
//            bullet fire control, hit scoring and 7-segment score display.
//            Optional round time limit enabled by defining ROUND_TIMER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_round_ctrl #(
    parameter int WIN_SCORE   = 9,
    parameter int COUNTDOWN   = 3,
    parameter int ROUND_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       fire_req,
    input  logic       hit,
    input  logic       miss,
    output logic       fire_grant,
    output logic [2:0] state,
    output logic [3:0] score,
    output logic [6:0] num
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNTDN  = 3'd1,
        S_PLAY   = 3'd2,
        S_FLIGHT = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    localparam logic [3:0] c_win   = 4'(WIN_SCORE);
    localparam logic [3:0] c_cntdn = 4'(COUNTDOWN);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_score, w_score_nxt;
    logic [3:0] r_cnt,   w_cnt_nxt;
    logic       r_grant, w_grant_nxt;
    logic [6:0] r_num;
    logic       r_start_prev;
    logic       w_start_press;
    logic [3:0] w_score_inc;
    logic [3:0] w_disp;

`ifdef ROUND_TIMER_EN
    localparam logic [7:0] c_round_ticks = 8'(ROUND_TICKS);
    logic [7:0] r_timer, w_timer_nxt;
`endif

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    assign w_start_press = start & ~r_start_prev;
    assign w_score_inc   = r_score + 4'd1;
    assign w_disp        = (r_state == S_CNTDN) ? r_cnt : r_score;

    always_comb begin
        w_state_nxt = r_state;
        w_score_nxt = r_score;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = 1'b0;
`ifdef ROUND_TIMER_EN
        w_timer_nxt = r_timer;
`endif
        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_start_press) begin
                    w_score_nxt = 4'd0;
                    w_cnt_nxt   = c_cntdn;
                    w_state_nxt = S_CNTDN;
`ifdef ROUND_TIMER_EN
                    w_timer_nxt = c_round_ticks;
`endif
                end
            end
            S_CNTDN: begin
                if (tick) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                if (fire_req) begin
                    w_grant_nxt = 1'b1;
                    w_state_nxt = S_FLIGHT;
                end
            end
            S_FLIGHT: begin
                if (hit) begin
                    w_score_nxt = w_score_inc;
                    w_state_nxt = (w_score_inc == c_win) ? S_OVER : S_PLAY;
                end else if (miss) begin
                    w_state_nxt = S_PLAY;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
`ifdef ROUND_TIMER_EN
        // Expiry overrides play/flight transitions; a coincident hit is still scored above.
        if (((r_state == S_PLAY) || (r_state == S_FLIGHT)) && tick) begin
            if (r_timer != 8'd0) begin
                w_timer_nxt = r_timer - 8'd1;
            end
            if (r_timer <= 8'd1) begin
                w_state_nxt = S_OVER;
                w_grant_nxt = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_score      <= 4'd0;
            r_cnt        <= 4'd0;
            r_grant      <= 1'b0;
            r_num        <= 7'h3F;
            r_start_prev <= 1'b1;
`ifdef ROUND_TIMER_EN
            r_timer      <= c_round_ticks;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_score      <= w_score_nxt;
            r_cnt        <= w_cnt_nxt;
            r_grant      <= w_grant_nxt;
            r_num        <= f_seg(w_disp);
            r_start_prev <= start;
`ifdef ROUND_TIMER_EN
            r_timer      <= w_timer_nxt;
`endif
        end
    end

    assign state      = r_state;
    assign score      = r_score;
    assign num        = r_num;
    assign fire_grant = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_game_round_ctrl.sv
// ============================================================================
// Module   : tb_game_round_ctrl
// Purpose  : Directed and randomized checks of game_round_ctrl against a
//            behavioural round model (default and WIN_SCORE=2 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_round_ctrl;

`ifdef ROUND_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       fire_req = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       grant0, grant1;
    logic [2:0] state0, state1;
    logic [3:0] score0, score1;
    logic [6:0] num0, num1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    game_round_ctrl dut0 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .fire_req(fire_req),
        .hit(hit), .miss(miss), .fire_grant(grant0), .state(state0),
        .score(score0), .num(num0)
    );

    game_round_ctrl #(.WIN_SCORE(2), .COUNTDOWN(3), .ROUND_TICKS(4)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .fire_req(fire_req),
        .hit(hit), .miss(miss), .fire_grant(grant1), .state(state1),
        .score(score1), .num(num1)
    );

    // Phases: 0 idle, 1 countdown, 2 play, 3 bullet flying, 4 game over.
    typedef struct {
        int phase;
        int hits;
        int count;
        int time_left;
        bit grant;
        int shown;
        bit prev_btn;
    } mdl_t;

    mdl_t m0, m1;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic mdl_t f_model(input mdl_t m, input int win, input int cd,
                                     input int rt, input bit r, input bit tk,
                                     input bit s, input bit fr, input bit h,
                                     input bit ms);
        mdl_t n;
        n = m;
        if (r) begin
            n.phase = 0; n.hits = 0; n.count = 0; n.time_left = rt;
            n.grant = 0; n.shown = 'h3F; n.prev_btn = 1;
            return n;
        end
        n.grant    = 0;
        n.prev_btn = s;
        n.shown    = seg_tab[(m.phase == 1) ? m.count : m.hits];
        if ((m.phase == 0 || m.phase == 4) && s && !m.prev_btn) begin
            n.hits = 0; n.count = cd; n.time_left = rt; n.phase = 1;
        end else if (m.phase == 1 && tk) begin
            n.count = m.count - 1;
            if (n.count == 0) n.phase = 2;
        end else if (m.phase == 2 && fr) begin
            n.grant = 1; n.phase = 3;
        end else if (m.phase == 3 && (h || ms)) begin
            if (h) n.hits = m.hits + 1;
            n.phase = (n.hits == win) ? 4 : 2;
        end
        if (TIMER_EN && (m.phase == 2 || m.phase == 3) && tk) begin
            n.time_left = m.time_left - 1;
            if (n.time_left <= 0) begin
                n.phase = 4; n.grant = 0;
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step(input bit r, input bit tk, input bit s, input bit fr,
                        input bit h, input bit ms);
        rst = r; tick = tk; start = s; fire_req = fr; hit = h; miss = ms;
        @(posedge clk);
        m0 = f_model(m0, 9, 3, 30, r, tk, s, fr, h, ms);
        m1 = f_model(m1, 2, 3, 4, r, tk, s, fr, h, ms);
        #1;
        chk("d0_state", 32'(state0), 32'(m0.phase));
        chk("d0_score", 32'(score0), 32'(m0.hits));
        chk("d0_num",   32'(num0),   32'(m0.shown));
        chk("d0_grant", 32'(grant0), 32'(m0.grant));
        chk("d1_state", 32'(state1), 32'(m1.phase));
        chk("d1_score", 32'(score1), 32'(m1.hits));
        chk("d1_num",   32'(num1),   32'(m1.shown));
        chk("d1_grant", 32'(grant1), 32'(m1.grant));
    endtask

    initial begin
        int  grants;
        bit  s_lvl;

        // Start held through reset must not begin a game.
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        chk("rst_num", 32'(num0), 32'h3F);
        chk("rst_state", 32'(state0), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
        chk("held_start_idle", 32'(state0), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("press_cntdn", 32'(state0), 32'd1);

        // Countdown 3,2,1 then play.
        step(0, 0, 1, 0, 0, 0);
        chk("cd_num3", 32'(num0), 32'h4F);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("cd_num2", 32'(num0), 32'h5B);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("cd_num1", 32'(num0), 32'h06);
        chk("cd_still", 32'(state0), 32'd1);
        step(0, 1, 1, 0, 0, 0);
        chk("cd_play", 32'(state0), 32'd2);

        // Held fire request yields a single grant.
        grants = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 1, 0, 0);
            grants += int'(grant0);
        end
        chk("one_grant", 32'(grants), 32'd1);
        chk("flight", 32'(state0), 32'd3);

        // Hit and miss together: hit wins.
        step(0, 0, 1, 0, 1, 1);
        chk("hm_score", 32'(score0), 32'd1);
        chk("hm_state", 32'(state0), 32'd2);
        step(0, 0, 1, 0, 0, 0);
        chk("hm_num", 32'(num0), 32'h06);

        // Second hit ends the WIN_SCORE=2 round; restart clears score.
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0);
        chk("w2_over", 32'(state1), 32'd4);
        chk("w2_score", 32'(score1), 32'd2);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("w2_restart_st", 32'(state1), 32'd1);
        chk("w2_restart_sc", 32'(score1), 32'd0);

        // Round timer expiry in flight (ROUND_TICKS=4 on the second instance).
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0);
        chk("timer_state", 32'(state1), TIMER_EN ? 32'd4 : 32'd3);
        step(0, 0, 1, 0, 1, 0);
        chk("timer_hit_ign", 32'(score1), TIMER_EN ? 32'd0 : 32'd1);

        // Randomized traffic.
        s_lvl = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(15) == 0) s_lvl = ~s_lvl;
            step($urandom_range(399) == 0, $urandom_range(3) == 0, s_lvl,
                 $urandom_range(1) == 1, $urandom_range(4) == 0,
                 $urandom_range(5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 The module SHALL take parameter WIN_SCORE, default 9, the hit count that ends a round (legal range 1..9).
REQ-002 The module SHALL take parameter COUNTDOWN, default 3, the pre-play countdown length in ticks (legal range 1..9).
REQ-003 The module SHALL take parameter ROUND_TICKS, default 30, the round time limit in ticks (8-bit counter).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port tick, input, 1 bit: one-clk enable pulse from the slow divider.
REQ-007 The module SHALL have port start, input, 1 bit: start button level.
REQ-008 The module SHALL have port fire_req, input, 1 bit: shooter attack request level.
REQ-009 The module SHALL have port hit, input, 1 bit: bullet struck the catcher, one-clk pulse.
REQ-010 The module SHALL have port miss, input, 1 bit: bullet left the field, one-clk pulse.
REQ-011 The module SHALL have port fire_grant, output, 1 bit: one-clk pulse that launches a bullet.
REQ-012 The module SHALL have port state, output, 3 bits: IDLE=0, CNTDN=1, PLAY=2, FLIGHT=3, OVER=4.
REQ-013 The module SHALL have port score, output, 4 bits: binary hit count.
REQ-014 The module SHALL have port num, output, 7 bits: active-high 7-segment pattern, bit0=a … bit6=g.

Function
REQ-015 The module SHALL detect a start press as a rising edge, start=1 with registered previous start=0; a held level SHALL produce no further presses.
REQ-016 In IDLE or OVER, a start press SHALL, on the next edge, clear score, load the countdown counter with COUNTDOWN, load the timer with ROUND_TICKS, and enter CNTDN.
REQ-017 In CNTDN, the countdown counter SHALL decrement on each tick; a tick while it equals 1 SHALL enter PLAY.
REQ-018 In PLAY, fire_req=1 SHALL assert fire_grant for exactly one clk and enter FLIGHT on the same edge, so at most one bullet is in flight.
REQ-019 In FLIGHT, fire_req SHALL be ignored and fire_grant SHALL stay 0.
REQ-020 In FLIGHT, hit SHALL increment score and enter PLAY, or enter OVER if the new score equals WIN_SCORE.
REQ-021 In FLIGHT, miss SHALL return to PLAY; if hit and miss are both asserted in the same clk, hit SHALL take priority.
REQ-022 hit and miss SHALL be ignored outside FLIGHT; start presses SHALL be ignored in CNTDN, PLAY and FLIGHT.
REQ-023 num SHALL decode the countdown counter in CNTDN and score in all other states, digits 0..9 (0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F).
REQ-024 num SHALL be registered and SHALL reflect a new value one clk after the counter or score changes.
REQ-025 score SHALL never exceed WIN_SCORE.

Reset
REQ-026 When rst=1 at a clk edge, the module SHALL set state=IDLE, score=0, countdown counter=0, timer=ROUND_TICKS, fire_grant=0 and num=7'h3F.
REQ-027 Reset SHALL set the previous-start register to 1, so a button held through reset does not start a game.
REQ-028 rst SHALL override every other input in the same cycle, including in mid-FLIGHT and mid-countdown.

Configuration
REQ-029 When ROUND_TIMER_EN is defined, the timer SHALL decrement on each tick in PLAY and FLIGHT, and reaching 0 SHALL enter OVER, abandoning any in-flight bullet.
REQ-030 With ROUND_TIMER_EN defined, a hit in the same clk as timer expiry SHALL be scored first, then the module SHALL enter OVER.
REQ-031 When ROUND_TIMER_EN is not defined, no timer logic SHALL exist and the round SHALL end only on WIN_SCORE.

Verification
REQ-032 Directed test: rst then start pulse, then 3 ticks -> state sequence 0→1→2; num sequence 3,2,1 patterns; PLAY entered on the 3rd tick.
REQ-033 Directed test: in PLAY, fire_req held high for 5 clk -> exactly one fire_grant pulse and state=3.
REQ-034 Directed test: in FLIGHT, hit and miss in the same clk -> score 0→1, state=2, num=7'h06.
REQ-035 Directed test: with WIN_SCORE=2, two fire/hit cycles -> state=4, score=2; a further start press gives score=0 and state=1.
REQ-036 Directed test: with ROUND_TIMER_EN defined and ROUND_TICKS=4, 4 ticks in FLIGHT with no hit -> state=4; a later hit is ignored and score is unchanged.
REQ-037 Directed test: start held high through rst release -> state stays 0 until start goes low then high.
